// File: rtl/mdio_pkg.sv
// Shared Clause-22 MDIO constants, frame layout and FSM states for the
// read and write management paths.
package mdio_pkg;
  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;

  localparam int PRE_LEN_DEF = 32;

  // Slot offsets counted from the end of the preamble.
  localparam int OFS_ST    = 0;
  localparam int OFS_OP    = 2;
  localparam int OFS_PHYAD = 4;
  localparam int OFS_REGAD = 9;
  localparam int OFS_TA    = 14;
  localparam int OFS_DATA  = 16;
  localparam int OFS_END   = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE
  } mdio_state_e;

  function automatic logic [13:0] mdio_hdr(input logic [1:0] op,
                                           input logic [4:0] phy,
                                           input logic [4:0] regad);
    return {MDIO_ST, op, phy, regad};
  endfunction
endpackage

// File: rtl/mdio_reader_mdc_gen.sv
// MDC divider: toggles mdc every DIV clk_45 cycles and flags the edge
// about to happen so the frame logic updates on the same clock.
module mdc_gen #(
  parameter int DIV = 5
) (
  input  logic clk_45,
  input  logic rst,
  output logic mdc,
  output logic rise_tk,
  output logic fall_tk
);
  logic [7:0] cnt;
  logic       tc;

  assign tc      = (cnt == 8'(DIV - 1));
  assign rise_tk = tc && !mdc;
  assign fall_tk = tc && mdc;

  always_ff @(posedge clk_45) begin
    if (rst) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (tc) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: rtl/mdio_reader.sv
// Clause-22 MDIO read master: drives preamble/ST/OP/PHYAD/REGAD, releases
// the bus for turnaround and shifts in the 16-bit register value.
module mdio_reader
  import mdio_pkg::*;
#(
  parameter int DIV     = 5,
  parameter int PRE_LEN = PRE_LEN_DEF
) (
  input  logic        clk_45,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  output logic        busy,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        ta_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);
  localparam logic [5:0] PRE_LAST  = 6'(PRE_LEN - 1);
  localparam logic [5:0] HDR_LAST  = 6'(PRE_LEN + OFS_TA - 1);
  localparam logic [5:0] TA_LAST   = 6'(PRE_LEN + OFS_DATA - 1);
  localparam logic [5:0] DATA_LAST = 6'(PRE_LEN + OFS_END - 1);

  mdio_state_e state;
  logic [5:0]  bit_idx;
  logic        pend;
  logic [13:0] hdr;
  logic [15:0] shift;
  logic        rise_tk, fall_tk;

  mdc_gen #(.DIV(DIV)) u_mdc (
    .clk_45  (clk_45),
    .rst     (rst),
    .mdc     (mdc),
    .rise_tk (rise_tk),
    .fall_tk (fall_tk)
  );

  always_ff @(posedge clk_45) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_idx  <= '0;
      pend     <= 1'b0;
      busy     <= 1'b0;
      hdr      <= '0;
      shift    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ta_err   <= 1'b0;
      mdio_o   <= 1'b1;
      mdio_oe  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (start && !busy) begin
        pend <= 1'b1;
        busy <= 1'b1;
        hdr  <= mdio_hdr(MDIO_OP_RD, phy_addr, reg_addr);
      end
      // PHY data launched on the previous rising edge is sampled here.
      if (rise_tk) begin
        if (state == S_TA && bit_idx == TA_LAST) ta_err <= mdio_i;
        if (state == S_DATA) shift <= {shift[14:0], mdio_i};
      end
      if (fall_tk) begin
        case (state)
          S_IDLE: if (pend) begin
            state   <= S_PRE;
            pend    <= 1'b0;
            bit_idx <= '0;
            mdio_oe <= 1'b1;
            mdio_o  <= 1'b1;
          end
          S_PRE: begin
            bit_idx <= bit_idx + 6'd1;
            if (bit_idx == PRE_LAST) begin
              state  <= S_HDR;
              mdio_o <= hdr[13];
              hdr    <= {hdr[12:0], 1'b0};
            end
          end
          S_HDR: begin
            bit_idx <= bit_idx + 6'd1;
            if (bit_idx == HDR_LAST) begin
              state   <= S_TA;
              mdio_oe <= 1'b0;
              mdio_o  <= 1'b1;
            end else begin
              mdio_o <= hdr[13];
              hdr    <= {hdr[12:0], 1'b0};
            end
          end
          S_TA: begin
            bit_idx <= bit_idx + 6'd1;
            if (bit_idx == TA_LAST) state <= S_DATA;
          end
          S_DATA: begin
            bit_idx <= bit_idx + 6'd1;
            // Completion is folded into this edge so busy drops with rd_valid.
            if (bit_idx == DATA_LAST) begin
              rd_data  <= shift;
              rd_valid <= 1'b1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
